fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  fetchingAddressWidth, 64, address width
  instructionWidth, 32, one instruction
  bundleSize, 128, four instructions from L1I
  PidSize, 20, process ID width
  TidSize, 16, thread ID width
  instructionCounterWidth, 64, major ID width
  queueDepth, 4, bundle entries, power of two
REQ-002 Ports (name, direction, width, meaning), one per line:
  clock_i  in  1  the block's single clock
  reset_i  in  1  synchronous, active-high reset
  bundleValid_i  in  1  L1I bundle valid
  bundle_i  in  bundleSize  instructions, slot 0 in the MSBs
  bundleAddress_i  in  fetchingAddressWidth  slot-0 address
  bundleLen_i  in  3  valid slot count
  bundlePid_i  in  PidSize  process ID
  bundleTid_i  in  TidSize  thread ID
  bundleStartMajId_i  in  instructionCounterWidth  slot-0 major ID
  flush_i  in  1  redirect, discard all contents
  decodeStall_i  in  1  decode cannot accept
  fetchStall_o  out  1  backpressure to L1I
  instValid_o  out  1  instruction presented
  inst_o  out  instructionWidth  instruction
  instAddress_o  out  fetchingAddressWidth  instruction address
  instPid_o  out  PidSize  process ID
  instTid_o  out  TidSize  thread ID
  instMajId_o  out  instructionCounterWidth  major ID
  empty_o  out  1  no entries held
  occupancy_o  out  3  entries held, 0..queueDepth
  overflow_o  out  1  sticky: bundle dropped while full

Function
REQ-003 Storage SHALL be a circular buffer of queueDepth entries; write and read pointers SHALL wrap modulo queueDepth.
REQ-004 A bundle SHALL be written on a clock edge with bundleValid_i=1, bundleLen_i!=0, flush_i=0, and a free entry after this cycle's pop.
REQ-005 bundleLen_i=0 SHALL write nothing; values 5..7 SHALL be stored as 4.
REQ-006 Outputs SHALL be combinational from the head entry and slot counter; a bundle written at edge N SHALL be presentable in the cycle after edge N.
REQ-007 instValid_o SHALL equal occupancy_o!=0; inst_o SHALL be the head slot's 32 bits.
REQ-008 instAddress_o SHALL be the head address + 4*slot, wrapping modulo 2^64; instMajId_o SHALL be the head major ID + slot, wrapping modulo 2^64.
REQ-009 Pop: on an edge with instValid_o=1 and decodeStall_i=0, slot SHALL increment; if slot=len-1, the head SHALL retire, read pointer SHALL advance and slot SHALL clear to 0.
REQ-010 A simultaneous write and head retire SHALL leave occupancy unchanged; a write at occupancy=queueDepth SHALL be accepted only if the head retires that edge.
REQ-011 A write attempt with no free entry SHALL drop the bundle and set overflow_o, which SHALL hold until reset.
REQ-012 fetchStall_o SHALL be 1 when occupancy_o >= queueDepth-1, leaving one entry for a bundle already in flight.
REQ-013 flush_i SHALL take priority over write and pop: at the edge, occupancy, pointers and slot SHALL clear and the incoming bundle SHALL be discarded; instValid_o SHALL be 0 the next cycle.
REQ-014 When empty, inst_o, instAddress_o, instPid_o, instTid_o and instMajId_o SHALL drive 0.

Reset
REQ-015 reset_i SHALL act on clock_i only and SHALL override flush, write and pop.
REQ-016 After reset: instValid_o=0, fetchStall_o=0, empty_o=1, occupancy_o=0, overflow_o=0, all data outputs 0.
REQ-017 Reset mid-drain SHALL discard all entries, including partially consumed ones.

Structure
REQ-018 Package fetch_pkg SHALL hold the width constants and the queue-entry record (bundle, address, len, Pid, Tid, major ID).
REQ-019 The block SHALL be a single module with no sub-module; storage and pointer logic SHALL be inline.

Verification
REQ-020 Reset, then one bundle (len=4, addr=0x1000, majId=10), no stall -> four instructions over 4 cycles at 0x1000/04/08/0C, majIds 10..13; empty_o=1 afterwards.
REQ-021 decodeStall_i=1, 3 bundles written -> fetchStall_o=1 after the third write; a 4th write is accepted; a 5th sets overflow_o=1 and occupancy_o stays 4.
REQ-022 Continuous writes of len=1 bundles with no stall -> one instruction per cycle, occupancy_o stays at 1, no overflow.
REQ-023 flush_i together with bundleValid_i while 2 entries are held -> next cycle occupancy_o=0 and instValid_o=0.
REQ-024 bundleLen_i=0 and bundleLen_i=6 -> the first writes nothing; the second yields exactly 4 instructions.
REQ-025 Address 0xFFFF_FFFF_FFFF_FFFC, len=2 -> second instruction address 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, the queue-entry record and slot helpers for the fetch queue.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned BUNDLE_W    = 128;
  localparam int unsigned PID_W       = 20;
  localparam int unsigned TID_W       = 16;
  localparam int unsigned MAJ_W       = 64;
  localparam int unsigned QUEUE_DEPTH = 4;
  localparam int unsigned LEN_W       = 3;
  localparam int unsigned OCC_W       = 3;
  localparam int unsigned SLOTS       = BUNDLE_W / INST_W;
  localparam int unsigned SLOT_W      = $clog2(SLOTS);

  // One stored bundle: raw instructions plus the metadata of its slot 0.
  typedef struct packed {
    logic [BUNDLE_W-1:0] bundle;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    len;
    logic [PID_W-1:0]    pid;
    logic [TID_W-1:0]    tid;
    logic [MAJ_W-1:0]    maj_id;
  } fq_entry_t;

  // Lengths above the slot count are stored as a full bundle.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len > LEN_W'(SLOTS)) begin
      res = LEN_W'(SLOTS);
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Slot 0 sits in the most significant bits of the bundle.
  function automatic logic [INST_W-1:0] slot_inst(input logic [BUNDLE_W-1:0] bundle,
                                                  input logic [SLOT_W-1:0]   slot);
    logic [INST_W-1:0] inst;
    case (slot)
      2'd0:    inst = bundle[BUNDLE_W-1 -: INST_W];
      2'd1:    inst = bundle[BUNDLE_W-1-INST_W -: INST_W];
      2'd2:    inst = bundle[BUNDLE_W-1-2*INST_W -: INST_W];
      default: inst = bundle[INST_W-1:0];
    endcase
    return inst;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: buffers L1I bundles in a circular buffer and hands them to
// decode one instruction per cycle, tracking the current slot of the head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned fetchingAddressWidth    = ADDR_W,
  parameter int unsigned instructionWidth        = INST_W,
  parameter int unsigned bundleSize              = BUNDLE_W,
  parameter int unsigned PidSize                 = PID_W,
  parameter int unsigned TidSize                 = TID_W,
  parameter int unsigned instructionCounterWidth = MAJ_W,
  parameter int unsigned queueDepth              = QUEUE_DEPTH
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               bundleValid_i,
  input  logic [bundleSize-1:0]              bundle_i,
  input  logic [fetchingAddressWidth-1:0]    bundleAddress_i,
  input  logic [2:0]                         bundleLen_i,
  input  logic [PidSize-1:0]                 bundlePid_i,
  input  logic [TidSize-1:0]                 bundleTid_i,
  input  logic [instructionCounterWidth-1:0] bundleStartMajId_i,
  input  logic                               flush_i,
  input  logic                               decodeStall_i,
  output logic                               fetchStall_o,
  output logic                               instValid_o,
  output logic [instructionWidth-1:0]        inst_o,
  output logic [fetchingAddressWidth-1:0]    instAddress_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic                               empty_o,
  output logic [2:0]                         occupancy_o,
  output logic                               overflow_o
);

  localparam int unsigned PtrW = $clog2(queueDepth);

  fq_entry_t            mem_q [queueDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 overflow_q, overflow_d;

  fq_entry_t            head_s;
  fq_entry_t            wr_entry_s;
  logic [LEN_W-1:0]     len_m1_s;
  logic                 valid_s;
  logic                 pop_s;
  logic                 retire_s;
  logic                 attempt_s;
  logic                 room_s;
  logic                 write_s;
  logic                 drop_s;

  // Head decode and write/pop/retire qualification for this cycle.
  always_comb begin
    head_s     = mem_q[rd_ptr_q];
    len_m1_s   = head_s.len - 3'd1;
    valid_s    = (count_q != 3'd0);
    pop_s      = valid_s && !decodeStall_i;
    retire_s   = pop_s && ({1'b0, slot_q} == len_m1_s);
    attempt_s  = bundleValid_i && (bundleLen_i != 3'd0) && !flush_i;
    // A full queue still takes a bundle if the head leaves on the same edge.
    room_s     = (count_q < OCC_W'(queueDepth)) || retire_s;
    write_s    = attempt_s && room_s;
    drop_s     = attempt_s && !room_s;
    wr_entry_s = '{bundle: bundle_i,
                   addr:   bundleAddress_i,
                   len:    clamp_len(bundleLen_i),
                   pid:    bundlePid_i,
                   tid:    bundleTid_i,
                   maj_id: bundleStartMajId_i};
  end

  // Next-state for pointers, occupancy, slot and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    slot_d     = slot_q;
    overflow_d = overflow_q | drop_s;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 3'd0;
      slot_d   = '0;
    end else begin
      if (retire_s) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        slot_d   = '0;
      end else if (pop_s) begin
        slot_d   = slot_q + SLOT_W'(1);
      end else begin
        slot_d   = slot_q;
      end
      if (write_s) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({write_s, retire_s})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers; reset wins over flush, write and pop.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 3'd0;
      slot_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      slot_q     <= slot_d;
      overflow_q <= overflow_d;
    end
  end

  // Bundle storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clock_i) begin
    if (write_s && !reset_i) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  // Presented instruction: head entry offset by the current slot, zero when empty.
  always_comb begin
    instValid_o  = valid_s;
    empty_o      = !valid_s;
    occupancy_o  = count_q;
    overflow_o   = overflow_q;
    // Keep one entry spare for a bundle the L1I already has in flight.
    fetchStall_o = (count_q >= OCC_W'(queueDepth - 1));
    if (valid_s) begin
      inst_o        = slot_inst(head_s.bundle, slot_q);
      instAddress_o = head_s.addr + {{(ADDR_W-SLOT_W-2){1'b0}}, slot_q, 2'b00};
      instPid_o     = head_s.pid;
      instTid_o     = head_s.tid;
      instMajId_o   = head_s.maj_id + {{(MAJ_W-SLOT_W){1'b0}}, slot_q};
    end else begin
      inst_o        = '0;
      instAddress_o = '0;
      instPid_o     = '0;
      instTid_o     = '0;
      instMajId_o   = '0;
    end
  end

endmodule
